// File: rtl/clk_2hz_gen.sv
// Divides clk down to a 50%-duty square wave at OUT_FREQ_HZ, plus a one-cycle
// tick on every rising edge of that wave. Both outputs are registered levels.
module clk_2hz_gen #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int OUT_FREQ_HZ = 2
) (
    input  logic clk,
    input  logic rst,
    output logic clk_out,
    output logic tick
);

    localparam int HALF = CLK_FREQ_HZ / (2 * OUT_FREQ_HZ);
    localparam int CW   = ($clog2(HALF) > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    if (HALF < 1) begin : g_bad_ratio
        $error("clk_2hz_gen: CLK_FREQ_HZ must be at least 2*OUT_FREQ_HZ");
    end

    logic [CW-1:0] cnt;

    // tick takes the value clk_out is about to toggle to, so it only fires on 0->1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            tick    <= ~clk_out;
        end else begin
            cnt     <= cnt + 1'b1;
            tick    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_2hz_gen.sv
// Bench for clk_2hz_gen: HALF=5 and HALF=1 instances checked against a per-edge
// arithmetic model via a scoreboard queue; default instance checked for its idle phase.
module tb_clk_2hz_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic co5, tk5, co1, tk1, cod, tkd;

    clk_2hz_gen #(.CLK_FREQ_HZ(20), .OUT_FREQ_HZ(2)) dut5 (
        .clk(clk), .rst(rst), .clk_out(co5), .tick(tk5));
    clk_2hz_gen #(.CLK_FREQ_HZ(4), .OUT_FREQ_HZ(2)) dut1 (
        .clk(clk), .rst(rst), .clk_out(co1), .tick(tk1));
    clk_2hz_gen dut_d (
        .clk(clk), .rst(rst), .clk_out(cod), .tick(tkd));

    always #5 clk = ~clk;

    typedef struct packed {
        logic co5;
        logic tk5;
        logic co1;
        logic tk1;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    // After active edge n since reset release: high during [HALF, 2*HALF), tick only at HALF
    function automatic logic exp_co(int n, int h);
        return ((n / h) % 2) == 1;
    endfunction

    function automatic logic exp_tk(int n, int h);
        return (n % (2 * h)) == h;
    endfunction

    task automatic push_exp();
        exp_t e;
        edge_n++;
        e.co5 = exp_co(edge_n, 5);
        e.tk5 = exp_tk(edge_n, 5);
        e.co1 = exp_co(edge_n, 1);
        e.tk1 = exp_tk(edge_n, 1);
        sb.push_back(e);
    endtask

    task automatic restart();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        edge_n = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        checks++;
        if ({co5, tk5, co1, tk1, cod, tkd} !== 6'b0) begin
            errors++;
            $display("FAIL reset_async: got %b want 000000", {co5, tk5, co1, tk1, cod, tkd});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({co5, tk5, co1, tk1, cod, tkd} !== 6'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got %b want 000000", i,
                         {co5, tk5, co1, tk1, cod, tkd});
            end
        end
    endtask

    task automatic test_first_edges();
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        edge_n = 0;
        for (int i = 0; i < 15; i++) begin
            push_exp();
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({co5, tk5} !== {e.co5, e.tk5}) begin
                errors++;
                $display("FAIL first_edges edge%0d: clk_out/tick got %b%b want %b%b",
                         i + 1, co5, tk5, e.co5, e.tk5);
            end
        end
    endtask

    task automatic test_periods();
        exp_t e;
        logic prev = co5;
        int   run = 1;
        int   ticks = 0;
        int   fall_ticks = 0;
        for (int i = 0; i < 40; i++) begin
            push_exp();
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({co5, tk5, co1, tk1} !== {e.co5, e.tk5, e.co1, e.tk1}) begin
                errors++;
                $display("FAIL periods edge%0d: got %b%b%b%b want %b%b%b%b", edge_n,
                         co5, tk5, co1, tk1, e.co5, e.tk5, e.co1, e.tk1);
            end
            if (tk5) ticks++;
            if (tk5 && !co5) fall_ticks++;
            if (co5 === prev) begin
                run++;
            end else begin
                checks++;
                if (run != 5) begin
                    errors++;
                    $display("FAIL phase_len edge%0d: got %0d want 5", edge_n, run);
                end
                run  = 1;
                prev = co5;
            end
        end
        checks++;
        if (ticks != 4) begin
            errors++;
            $display("FAIL tick_count: got %0d want 4", ticks);
        end
        checks++;
        if (fall_ticks != 0) begin
            errors++;
            $display("FAIL tick_on_fall: got %0d want 0", fall_ticks);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        restart();
        for (int i = 0; i < 8; i++) begin
            push_exp();
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({co5, tk5} !== {e.co5, e.tk5}) begin
                errors++;
                $display("FAIL pre_reset edge%0d: got %b%b want %b%b",
                         i + 1, co5, tk5, e.co5, e.tk5);
            end
        end
        checks++;
        if (dut5.cnt !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset_cnt: got %0d want 3", dut5.cnt);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({co5, tk5} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: got %b%b want 00", co5, tk5);
        end
        @(negedge clk);
        rst = 1'b1;
        edge_n = 0;
        for (int i = 0; i < 6; i++) begin
            push_exp();
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({co5, tk5} !== {e.co5, e.tk5}) begin
                errors++;
                $display("FAIL post_reset edge%0d: got %b%b want %b%b",
                         i + 1, co5, tk5, e.co5, e.tk5);
            end
        end
    endtask

    task automatic test_half1();
        exp_t e;
        restart();
        for (int i = 0; i < 8; i++) begin
            push_exp();
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({co1, tk1} !== {e.co1, e.tk1}) begin
                errors++;
                $display("FAIL half1 edge%0d: got %b%b want %b%b",
                         i + 1, co1, tk1, e.co1, e.tk1);
            end
        end
    endtask

    task automatic test_default();
        int busy = 0;
        restart();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (cod !== 1'b0 || tkd !== 1'b0) busy++;
        end
        checks++;
        if (busy != 0) begin
            errors++;
            $display("FAIL default_idle: got %0d active cycles want 0", busy);
        end
        checks++;
        if (dut_d.HALF != 12_500_000) begin
            errors++;
            $display("FAIL default_half: got %0d want 12500000", dut_d.HALF);
        end
        checks++;
        if (dut_d.cnt !== 24'(edge_n)) begin
            errors++;
            $display("FAIL default_cnt: got %0d want %0d", dut_d.cnt, edge_n);
        end
    endtask

    initial begin
        test_reset();
        test_first_edges();
        test_periods();
        test_async_reset();
        test_half1();
        test_default();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
